// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the 8x8 register file with a destination busy scoreboard.
// Define WB_ROUND_ROBIN_EN to alternate ALU/MEM on different-address conflicts; otherwise MEM has fixed priority.
module regfile_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ALU_VALID,
    input  logic [ADDR_W-1:0]    ALU_ADDR,
    input  logic [DATA_W-1:0]    ALU_DATA,
    output logic                 ALU_READY,
    input  logic                 MEM_VALID,
    input  logic [ADDR_W-1:0]    MEM_ADDR,
    input  logic [DATA_W-1:0]    MEM_DATA,
    output logic                 MEM_READY,
    input  logic                 ISSUE_VALID,
    input  logic [ADDR_W-1:0]    ISSUE_ADDR,
    output logic                 RF_WRITE,
    output logic [ADDR_W-1:0]    RF_INADDRESS,
    output logic [DATA_W-1:0]    RF_IN,
    output logic [2**ADDR_W-1:0] BUSY_MASK
);

    localparam int NREG = 2**ADDR_W;

    logic              alu_full, mem_full;
    logic [ADDR_W-1:0] alu_addr_q, mem_addr_q;
    logic [DATA_W-1:0] alu_data_q, mem_data_q;
    logic              mem_older;
    logic              alu_take, mem_take;
    logic              grant_alu, grant_mem;
    logic [NREG-1:0]   busy_q, busy_next;

`ifdef WB_ROUND_ROBIN_EN
    typedef enum logic {SRC_ALU, SRC_MEM} src_t;
    src_t last_grant;
`endif

    assign ALU_READY = !alu_full;
    assign MEM_READY = !mem_full;
    assign BUSY_MASK = busy_q;

    assign alu_take = ALU_VALID && !alu_full;
    assign mem_take = MEM_VALID && !mem_full;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_full && mem_full) begin
            if (alu_addr_q == mem_addr_q) begin
                if (mem_older) grant_mem = 1'b1;
                else           grant_alu = 1'b1;
            end else begin
`ifdef WB_ROUND_ROBIN_EN
                if (last_grant == SRC_ALU) grant_mem = 1'b1;
                else                       grant_alu = 1'b1;
`else
                grant_mem = 1'b1;
`endif
            end
        end else if (alu_full) begin
            grant_alu = 1'b1;
        end else if (mem_full) begin
            grant_mem = 1'b1;
        end
    end

    // Issue is applied after the grant clear so a same-edge set wins.
    always_comb begin
        busy_next = busy_q;
        if (grant_alu)   busy_next[alu_addr_q] = 1'b0;
        if (grant_mem)   busy_next[mem_addr_q] = 1'b0;
        if (ISSUE_VALID) busy_next[ISSUE_ADDR] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_full     <= 1'b0;
            mem_full     <= 1'b0;
            mem_older    <= 1'b0;
            RF_WRITE     <= 1'b0;
            RF_INADDRESS <= '0;
            RF_IN        <= '0;
            busy_q       <= '0;
`ifdef WB_ROUND_ROBIN_EN
            last_grant   <= SRC_ALU;
`endif
        end else begin
            if (grant_alu) alu_full <= 1'b0;
            if (grant_mem) mem_full <= 1'b0;
            if (alu_take) begin
                alu_full   <= 1'b1;
                alu_addr_q <= ALU_ADDR;
                alu_data_q <= ALU_DATA;
            end
            if (mem_take) begin
                mem_full   <= 1'b1;
                mem_addr_q <= MEM_ADDR;
                mem_data_q <= MEM_DATA;
            end

            // Flag means the waiting MEM entry predates the ALU entry; only an ALU
            // capture behind a still-held MEM entry makes MEM the older one.
            if (alu_take && mem_full && !grant_mem) mem_older <= 1'b1;
            else if (mem_take || grant_mem)         mem_older <= 1'b0;

            RF_WRITE <= grant_alu || grant_mem;
            if (grant_alu) begin
                RF_INADDRESS <= alu_addr_q;
                RF_IN        <= alu_data_q;
            end else if (grant_mem) begin
                RF_INADDRESS <= mem_addr_q;
                RF_IN        <= mem_data_q;
            end

            busy_q <= busy_next;
`ifdef WB_ROUND_ROBIN_EN
            if (grant_alu)      last_grant <= SRC_ALU;
            else if (grant_mem) last_grant <= SRC_MEM;
`endif
        end
    end

endmodule
